// File: rtl/key_expand_engine.sv
// Word-serial AES-128/192/256 key schedule: expands the loaded key one word per cycle
// and streams the 128-bit round keys 0..Nr over a valid/ready interface.
module key_expand_engine #(
    parameter logic ENABLE_192 = 1'b1,
    parameter logic ENABLE_256 = 1'b1,
    parameter logic SBOX_REG   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] key_in,
    input  logic [1:0]   mode,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         err
);

    typedef enum logic {IDLE, EXPAND} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t       state_reg, state_next;
    logic [1:0]   mode_reg;
    logic [31:0]  win_reg  [8];
    logic [31:0]  win_next [8];
    logic [31:0]  acc_reg  [4];
    logic [5:0]   i_reg;
    logic [2:0]   j_reg;
    logic [7:0]   rcon_reg;
    logic [127:0] rk_out_reg;
    logic [3:0]   rk_idx_reg;
    logic         rk_valid_reg;
    logic         rk_last_reg;
    logic         err_reg;
    logic [31:0]  sub_q_reg;
    logic         sub_ok_reg;

    logic         mode_legal;
    logic         load;
    logic         accept;
    logic         last_accept;
    logic [2:0]   nk_m1;
    logic [3:0]   nr;
    logic [5:0]   nk6;
    logic [5:0]   w_total;
    logic         key_phase;
    logic         gen_active;
    logic         need_rot;
    logic         need_sub;
    logic         group_end;
    logic         out_free;
    logic         stall_sbox;
    logic         advance;
    logic         transfer;
    logic [31:0]  last_word;
    logic [31:0]  temp_in;
    logic [31:0]  sub_comb;
    logic [31:0]  sub_use;
    logic [31:0]  temp;
    logic [31:0]  new_word;

    always_comb begin
        nk_m1   = 3'd3;
        nr      = 4'd10;
        w_total = 6'd44;
        case (mode_reg)
            2'b01: begin nk_m1 = 3'd5; nr = 4'd12; w_total = 6'd52; end
            2'b10: begin nk_m1 = 3'd7; nr = 4'd14; w_total = 6'd60; end
            default: ;
        endcase
    end

    always_comb begin
        mode_legal = 1'b0;
        case (mode)
            2'b00:   mode_legal = 1'b1;
            2'b01:   mode_legal = ENABLE_192;
            2'b10:   mode_legal = ENABLE_256;
            default: mode_legal = 1'b0;
        endcase
    end

    assign nk6         = {3'b000, nk_m1} + 6'd1;
    assign load        = (state_reg == IDLE) && key_valid && mode_legal;
    assign accept      = rk_valid_reg && rk_ready;
    assign last_accept = accept && rk_last_reg;

    // j_reg tracks i mod Nk so the Rot/Sub decisions need no divider.
    assign key_phase  = i_reg < nk6;
    assign gen_active = (state_reg == EXPAND) && (i_reg < w_total);
    assign need_rot   = !key_phase && (j_reg == 3'd0);
    assign need_sub   = need_rot || (!key_phase && (nk_m1 == 3'd7) && (j_reg == 3'd4));
    assign last_word  = win_reg[nk_m1];
    assign temp_in    = need_rot ? {last_word[23:0], last_word[31:24]} : last_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_comb[8*gi +: 8] = sbox(temp_in[8*gi +: 8]);
        end
    endgenerate

    assign sub_use = SBOX_REG ? sub_q_reg : sub_comb;
    assign temp    = need_rot ? (sub_use ^ {rcon_reg, 24'h000000})
                   : need_sub ? sub_use : last_word;
    assign new_word = key_phase ? win_reg[i_reg[2:0]] : (win_reg[0] ^ temp);

    // Only the word that completes a round key waits on the output register.
    assign group_end  = i_reg[1:0] == 2'd3;
    assign out_free   = !rk_valid_reg || rk_ready;
    assign stall_sbox = SBOX_REG && gen_active && need_sub && !sub_ok_reg;
    assign advance    = gen_active && !(group_end && !out_free) && !stall_sbox;
    assign transfer   = advance && group_end;

    generate
        if (SBOX_REG) begin : g_sbox_reg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sub_q_reg  <= '0;
                    sub_ok_reg <= 1'b0;
                end else if (load || advance) begin
                    sub_ok_reg <= 1'b0;
                end else if (stall_sbox) begin
                    sub_q_reg  <= sub_comb;
                    sub_ok_reg <= 1'b1;
                end
            end
        end else begin : g_sbox_comb
            assign sub_q_reg  = '0;
            assign sub_ok_reg = 1'b0;
        end
    endgenerate

    // Window: win[0] is w[i-Nk], win[Nk-1] is w[i-1]; key words stay put until i reaches Nk.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_win
            assign win_next[gi] = load ? key_in[255-32*gi -: 32]
                                : (advance && !key_phase)
                                    ? ((nk_m1 == 3'(gi)) ? new_word : win_reg[(gi+1)%8])
                                    : win_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) win_reg[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) win_reg[k] <= win_next[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = EXPAND;
            EXPAND:  if (last_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg     <= 2'b00;
            i_reg        <= '0;
            j_reg        <= '0;
            rcon_reg     <= 8'h01;
            for (int k = 0; k < 4; k++) acc_reg[k] <= '0;
            rk_out_reg   <= '0;
            rk_idx_reg   <= '0;
            rk_valid_reg <= 1'b0;
            rk_last_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= (state_reg == IDLE) && key_valid && !mode_legal;
            if (load) begin
                mode_reg <= mode;
                i_reg    <= '0;
                j_reg    <= '0;
                rcon_reg <= 8'h01;
            end else if (advance) begin
                i_reg   <= i_reg + 6'd1;
                j_reg   <= (j_reg == nk_m1) ? 3'd0 : j_reg + 3'd1;
                acc_reg[i_reg[1:0]] <= new_word;
                if (need_rot) rcon_reg <= xtime(rcon_reg);
            end
            if (transfer) begin
                rk_out_reg   <= {acc_reg[0], acc_reg[1], acc_reg[2], new_word};
                rk_idx_reg   <= i_reg[5:2];
                rk_last_reg  <= i_reg[5:2] == nr;
                rk_valid_reg <= 1'b1;
            end else if (accept) begin
                rk_valid_reg <= 1'b0;
                rk_last_reg  <= 1'b0;
            end
        end
    end

    assign key_ready = state_reg == IDLE;
    assign busy      = state_reg == EXPAND;
    assign rk_out    = rk_out_reg;
    assign rk_idx    = rk_idx_reg;
    assign rk_valid  = rk_valid_reg;
    assign rk_last   = rk_last_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_key_expand_engine.sv
// Bench for key_expand_engine: FIPS-197 vectors, randomized keys/backpressure against a
// word-array key-schedule model, illegal modes, registered S-box timing and mid-run reset.
module tb_key_expand_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [255:0] key_in;
    logic [1:0]   mode;
    logic         key_valid_a, key_valid_b;
    logic         rk_ready;

    logic         key_ready_a, rk_last_a, rk_valid_a, busy_a, err_a;
    logic [127:0] rk_out_a;
    logic [3:0]   rk_idx_a;
    logic         key_ready_b, rk_last_b, rk_valid_b, busy_b, err_b;
    logic [127:0] rk_out_b;
    logic [3:0]   rk_idx_b;

    key_expand_engine #(.ENABLE_192(1'b1), .ENABLE_256(1'b1), .SBOX_REG(1'b0)) dut_a (
        .clk(clk), .reset(reset), .key_in(key_in), .mode(mode), .key_valid(key_valid_a),
        .key_ready(key_ready_a), .rk_out(rk_out_a), .rk_idx(rk_idx_a), .rk_last(rk_last_a),
        .rk_valid(rk_valid_a), .rk_ready(rk_ready), .busy(busy_a), .err(err_a)
    );

    key_expand_engine #(.ENABLE_192(1'b0), .ENABLE_256(1'b0), .SBOX_REG(1'b1)) dut_b (
        .clk(clk), .reset(reset), .key_in(key_in), .mode(mode), .key_valid(key_valid_b),
        .key_ready(key_ready_b), .rk_out(rk_out_b), .rk_idx(rk_idx_b), .rk_last(rk_last_b),
        .rk_valid(rk_valid_b), .rk_ready(rk_ready), .busy(busy_b), .err(err_b)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [10];
    logic [127:0] exp_rk [15];
    logic [127:0] cap [15];
    int           cap_cyc [15];

    logic         sel;
    logic         cur_valid, cur_last, cur_key_ready, cur_busy, cur_err;
    logic [127:0] cur_out;
    logic [3:0]   cur_idx;

    always_comb begin
        cur_valid     = sel ? rk_valid_b  : rk_valid_a;
        cur_last      = sel ? rk_last_b   : rk_last_a;
        cur_key_ready = sel ? key_ready_b : key_ready_a;
        cur_busy      = sel ? busy_b      : busy_a;
        cur_err       = sel ? err_b       : err_a;
        cur_out       = sel ? rk_out_b    : rk_out_a;
        cur_idx       = sel ? rk_idx_b    : rk_idx_a;
    end

    typedef struct packed {
        logic [255:0] key;
        logic [1:0]   mode;
        logic [7:0]   duty;
        logic [3:0]   idx;
        logic [127:0] exp;
    } kat_t;
    kat_t kat [8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ x;
            x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box table: brute-force multiplicative inverse, then the affine transform.
    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic int nr_of(input logic [1:0] m);
        return (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
    endfunction

    task automatic model_expand(input logic [255:0] k, input logic [1:0] m);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [255:0] kk;
        int nk, nr;
        nr = nr_of(m);
        nk = nr - 6;
        kk = k;
        for (int i = 0; i < nk; i++) begin
            w[i] = kk[255:224];
            kk   = kk << 32;
        end
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
            else if (nk == 8 && i % 8 == 4) t = sub_word(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input logic s, input logic [255:0] k, input logic [1:0] m);
        key_in = k;
        mode   = m;
        if (s) key_valid_b = 1'b1;
        else   key_valid_a = 1'b1;
        @(posedge clk); #1;
        key_valid_a = 1'b0;
        key_valid_b = 1'b0;
    endtask

    // Consume one full stream; starts just after the load handshake edge (cycle 0).
    task automatic run_stream(input int duty, input int nr);
        int cyc = 0;
        int got = 0;
        logic stalled = 1'b0;
        logic [127:0] hold_out = '0;
        logic [3:0] hold_idx = '0;
        logic rdy;
        while (got <= nr && cyc < 3000) begin
            rdy = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            if (stalled) begin
                check("stall_valid", 128'(cur_valid), 128'(1));
                check("stall_data", cur_out, hold_out);
                check("stall_idx", 128'(cur_idx), 128'(hold_idx));
            end
            if (cur_valid) begin
                if (rdy) begin
                    check("rk_data", cur_out, exp_rk[got]);
                    check("rk_idx", 128'(cur_idx), 128'(got));
                    check("rk_last", 128'(cur_last), 128'(got == nr));
                    cap[got] = cur_out;
                    cap_cyc[got] = cyc;
                    $display("rk dut=%0d idx=%0d data=%h cyc=%0d", sel, cur_idx, cur_out, cyc);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    hold_out = cur_out;
                    hold_idx = cur_idx;
                end
            end
            rk_ready = rdy;
            @(posedge clk); #1;
            cyc++;
        end
        rk_ready = 1'b1;
        if (got <= nr) check("stream_timeout", 128'(got), 128'(nr + 1));
        check("key_ready_after_last", 128'(cur_key_ready), 128'(1));
        check("busy_after_last", 128'(cur_busy), 128'(0));
    endtask

    task automatic do_stream(input logic s, input logic [255:0] k, input logic [1:0] m,
                             input int duty);
        sel = s;
        model_expand(k, m);
        check("key_ready_before_load", 128'(cur_key_ready), 128'(1));
        load_key(s, k, m);
        run_stream(duty, nr_of(m));
    endtask

    task automatic illegal_load(input logic s, input logic [1:0] m);
        sel = s;
        load_key(s, rand256(), m);
        $display("illegal load dut=%0d mode=%0d err=%0d", s, m, cur_err);
        check("illegal_err_pulse", 128'(cur_err), 128'(1));
        check("illegal_key_ready", 128'(cur_key_ready), 128'(1));
        check("illegal_busy", 128'(cur_busy), 128'(0));
        @(posedge clk); #1;
        check("illegal_err_clears", 128'(cur_err), 128'(0));
        for (int c = 0; c < 4; c++) begin
            check("illegal_no_valid", 128'(cur_valid), 128'(0));
            check("illegal_ready_held", 128'(cur_key_ready), 128'(1));
            @(posedge clk); #1;
        end
    endtask

    task automatic check_a_idle_zero(input string tag);
        check({tag, "_rk_out"}, rk_out_a, 128'(0));
        check({tag, "_rk_idx"}, 128'(rk_idx_a), 128'(0));
        check({tag, "_rk_valid"}, 128'(rk_valid_a), 128'(0));
        check({tag, "_rk_last"}, 128'(rk_last_a), 128'(0));
        check({tag, "_busy"}, 128'(busy_a), 128'(0));
        check({tag, "_err"}, 128'(err_a), 128'(0));
        check({tag, "_key_ready"}, 128'(key_ready_a), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b0;
        key_in = '0;
        mode = 2'b00;
        key_valid_a = 1'b0;
        key_valid_b = 1'b0;
        rk_ready = 1'b1;
        sel = 1'b0;
        build_tables();

        kat[0] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, mode: 2'd0, duty: 8'd100,
                   idx: 4'd0, exp: 128'h2b7e151628aed2a6abf7158809cf4f3c};
        kat[1] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, mode: 2'd0, duty: 8'd100,
                   idx: 4'd1, exp: 128'ha0fafe1788542cb123a339392a6c7605};
        kat[2] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, mode: 2'd0, duty: 8'd100,
                   idx: 4'd10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        kat[3] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, mode: 2'd0, duty: 8'd30,
                   idx: 4'd10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        kat[4] = '{key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, mode: 2'd1,
                   duty: 8'd100, idx: 4'd1, exp: 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        kat[5] = '{key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, mode: 2'd1,
                   duty: 8'd30, idx: 4'd12, exp: 128'he98ba06f448c773c8ecc720401002202};
        kat[6] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                   mode: 2'd2, duty: 8'd100, idx: 4'd2, exp: 128'h9ba354118e6925afa51a8b5f2067fcde};
        kat[7] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                   mode: 2'd2, duty: 8'd30, idx: 4'd14, exp: 128'hfe4890d1e6188d0b046df344706c631e};

        repeat (3) @(posedge clk);
        #1;
        check_a_idle_zero("in_reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_a_idle_zero("after_reset");

        for (int k = 0; k < 8; k++) begin
            do_stream(1'b0, kat[k].key, kat[k].mode, int'(kat[k].duty));
            check($sformatf("kat%0d", k), cap[kat[k].idx], kat[k].exp);
        end

        do_stream(1'b0, kat[0].key, 2'd0, 100);
        check("lat_rk0", 128'(cap_cyc[0]), 128'(4));
        check("lat_rk1_gap", 128'(cap_cyc[1] - cap_cyc[0]), 128'(4));
        check("lat_rk10", 128'(cap_cyc[10]), 128'(44));

        for (int n = 0; n < 6; n++)
            do_stream(1'b0, rand256(), 2'(n % 3), (n < 3) ? 30 : 100);

        illegal_load(1'b0, 2'b11);
        illegal_load(1'b1, 2'b01);
        illegal_load(1'b1, 2'b10);
        illegal_load(1'b1, 2'b11);

        do_stream(1'b1, kat[0].key, 2'd0, 100);
        check("sboxreg_kat_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("sboxreg_lat_rk0", 128'(cap_cyc[0]), 128'(4));
        check("sboxreg_lat_rk10", 128'(cap_cyc[10]), 128'(54));
        do_stream(1'b1, rand256(), 2'd0, 30);

        sel = 1'b0;
        model_expand(kat[0].key, 2'd0);
        load_key(1'b0, kat[0].key, 2'd0);
        c = 0;
        while (!(rk_valid_a && rk_idx_a == 4'd5) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_idx5", 128'(c < 200), 128'(1));
        $display("reset asserted at rk_idx=%0d", rk_idx_a);
        reset = 1'b0;
        #1;
        check_a_idle_zero("mid_reset");
        @(posedge clk); #1;
        check_a_idle_zero("mid_reset_held");
        reset = 1'b1;
        @(posedge clk); #1;
        check_a_idle_zero("mid_reset_release");
        do_stream(1'b0, rand256(), 2'd2, 30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
